// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU port, debug/loader port and unified memory port around mem_port_arbiter.
// The arbiter uses the slave view; requesters and the memory side use the master view.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;
   logic          cpu_stall;

   logic          dbg_req;
   logic          dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic [DW-1:0] dbg_rdata;
   logic          dbg_ack;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack, cpu_stall,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_rdata, dbg_ack,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack, cpu_stall,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_rdata, dbg_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the unified MIPS memory between the CPU port and the debug/loader port:
// latch the winner, issue one access, wait MEM_LAT cycles, ack the owner.
module mem_port_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MEM_LAT   = 1,
   parameter int MAX_GRANT = 4
) (
   input logic              clk,
   input logic              reset,
   mem_port_arbiter_if.slave bus
);
   localparam int CW = $clog2(MAX_GRANT + 1);
   localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t        r_state;
   state_t        w_next;
   logic          r_owner;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_cpu_rdata;
   logic [DW-1:0] r_dbg_rdata;
   logic [CW-1:0] r_cnt;
   logic [WW-1:0] r_wait;

   logic w_any;
   logic w_grant_dbg;
   logic w_wait_last;
   logic w_mem_en;
   logic w_mem_we;
   logic w_cpu_ack;
   logic w_dbg_ack;

   assign w_any       = bus.cpu_req | bus.dbg_req;
   // The CPU yields only after MAX_GRANT back-to-back wins against a waiting debug request.
   assign w_grant_dbg = bus.dbg_req & (~bus.cpu_req | (r_cnt == CW'(MAX_GRANT)));
   assign w_wait_last = (r_wait == WW'(MEM_LAT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_mem_en  = 1'b0;
      w_mem_we  = 1'b0;
      w_cpu_ack = 1'b0;
      w_dbg_ack = 1'b0;
      case (r_state)
         S_IDLE:  if (w_any) w_next = S_ISSUE;
         S_ISSUE: begin
            w_mem_en = 1'b1;
            w_mem_we = r_we;
            w_next   = S_WAIT;
         end
         S_WAIT:  if (w_wait_last) w_next = S_DONE;
         S_DONE: begin
            w_cpu_ack = ~r_owner;
            w_dbg_ack = r_owner;
            w_next    = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_owner     <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cpu_rdata <= '0;
         r_dbg_rdata <= '0;
         r_cnt       <= '0;
         r_wait      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_owner <= w_grant_dbg;
                  r_we    <= w_grant_dbg ? bus.dbg_we    : bus.cpu_we;
                  r_addr  <= w_grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
                  r_wdata <= w_grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                  if (w_grant_dbg || !bus.dbg_req) r_cnt <= '0;
                  else if (r_cnt != CW'(MAX_GRANT)) r_cnt <= r_cnt + 1'b1;
               end
            end
            S_ISSUE: r_wait <= '0;
            S_WAIT: begin
               r_wait <= r_wait + 1'b1;
               if (w_wait_last && !r_we) begin
                  if (r_owner) r_dbg_rdata <= bus.mem_rdata;
                  else         r_cpu_rdata <= bus.mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_en    = w_mem_en;
   assign bus.mem_we    = w_mem_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.cpu_ack   = w_cpu_ack;
   assign bus.dbg_ack   = w_dbg_ack;
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.dbg_rdata = r_dbg_rdata;
   assign bus.cpu_stall = bus.cpu_req & ~w_cpu_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters (MEM_LAT=1 and MEM_LAT=3) checked every cycle against a timeline model
// of grants (mem_en at grant+1, ack at grant+2+LAT, next arbitration at grant+3+LAT).
module tb_mem_port_arbiter;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXG = 4;
   localparam int M_HOLD = 0, M_ONESHOT = 1, M_RANDOM = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        req_v   [2][2];
   logic        we_v    [2][2];
   logic [31:0] addr_v  [2][2];
   logic [31:0] wdata_v [2][2];
   logic [31:0] mrd_v   [2];

   logic        o_en    [2];
   logic        o_we    [2];
   logic [31:0] o_addr  [2];
   logic [31:0] o_wdata [2];
   logic [31:0] o_rd    [2][2];
   logic        o_ack   [2][2];
   logic        o_stall [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_port_arbiter_if #(.AW(AW), .DW(DW)) u_bus ();
      assign u_bus.cpu_req   = req_v[g][0];
      assign u_bus.cpu_we    = we_v[g][0];
      assign u_bus.cpu_addr  = addr_v[g][0];
      assign u_bus.cpu_wdata = wdata_v[g][0];
      assign u_bus.dbg_req   = req_v[g][1];
      assign u_bus.dbg_we    = we_v[g][1];
      assign u_bus.dbg_addr  = addr_v[g][1];
      assign u_bus.dbg_wdata = wdata_v[g][1];
      assign u_bus.mem_rdata = mrd_v[g];
      assign o_en[g]     = u_bus.mem_en;
      assign o_we[g]     = u_bus.mem_we;
      assign o_addr[g]   = u_bus.mem_addr;
      assign o_wdata[g]  = u_bus.mem_wdata;
      assign o_rd[g][0]  = u_bus.cpu_rdata;
      assign o_rd[g][1]  = u_bus.dbg_rdata;
      assign o_ack[g][0] = u_bus.cpu_ack;
      assign o_ack[g][1] = u_bus.dbg_ack;
      assign o_stall[g]  = u_bus.cpu_stall;

      mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT((g == 0) ? 1 : 3), .MAX_GRANT(MAXG)) u_dut (
         .clk   (clk),
         .reset (reset),
         .bus   (u_bus.slave)
      );
   end

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // reference model state
   int          free_at [2];
   int          en_cyc  [2];
   int          ack_cyc [2];
   int          m_owner [2];
   logic        m_we    [2];
   logic [31:0] m_addr  [2];
   logic [31:0] m_wdata [2];
   logic [31:0] m_rd    [2][2];
   int          m_cnt   [2];

   // memory model and requester agents
   logic [31:0] memv   [2][64];
   int          rd_due [2];
   logic [31:0] rd_val [2];
   int          mode   [2][2];
   logic        ackp   [2][2];

   // observations used by the directed checks
   int          ack_cnt   [2][2];
   int          last_ack  [2][2];
   logic [31:0] rd_at_ack [2][2];
   int          last_en   [2];
   logic        last_en_we[2];
   logic [31:0] last_en_addr [2];
   logic [31:0] last_en_wdata[2];
   bit          log_order = 0;
   int          order_q[$];

   function automatic int lat(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
      end
   endtask

   task automatic new_fields(input int d, input int p);
      we_v[d][p]    = 1'($urandom_range(1));
      addr_v[d][p]  = 32'($urandom_range(63));
      wdata_v[d][p] = $urandom;
   endtask

   task automatic model_reset(input int d);
      free_at[d] = 0; en_cyc[d] = -100; ack_cyc[d] = -100; rd_due[d] = -100;
      m_owner[d] = 0; m_we[d] = 1'b0; m_addr[d] = '0; m_wdata[d] = '0;
      m_rd[d][0] = '0; m_rd[d][1] = '0; m_cnt[d] = 0;
   endtask

   task automatic agent(input int d, input int p);
      case (mode[d][p])
         M_ONESHOT: if (ackp[d][p]) req_v[d][p] = 1'b0;
         M_RANDOM: begin
            if (req_v[d][p] && ackp[d][p]) begin
               if ($urandom_range(1) == 0) req_v[d][p] = 1'b0;
               else new_fields(d, p);
            end else if (!req_v[d][p]) begin
               if ($urandom_range(3) == 0) begin req_v[d][p] = 1'b1; new_fields(d, p); end
            end else if ($urandom_range(4) == 0) new_fields(d, p);
            else if ($urandom_range(19) == 0) req_v[d][p] = 1'b0;
         end
         default: ;
      endcase
   endtask

   task automatic check_and_update(input int d);
      logic exp_en, exp_ack0, exp_ack1;
      int   win;
      exp_en   = (cyc == en_cyc[d]);
      exp_ack0 = (cyc == ack_cyc[d]) && (m_owner[d] == 0);
      exp_ack1 = (cyc == ack_cyc[d]) && (m_owner[d] == 1);
      chk("mem_en",    d, o_en[d],     exp_en);
      chk("mem_we",    d, o_we[d],     exp_en & m_we[d]);
      chk("mem_addr",  d, o_addr[d],   m_addr[d]);
      chk("mem_wdata", d, o_wdata[d],  m_wdata[d]);
      chk("cpu_ack",   d, o_ack[d][0], exp_ack0);
      chk("dbg_ack",   d, o_ack[d][1], exp_ack1);
      chk("cpu_stall", d, o_stall[d],  req_v[d][0] & ~exp_ack0);
      chk("cpu_rdata", d, o_rd[d][0],  m_rd[d][0]);
      chk("dbg_rdata", d, o_rd[d][1],  m_rd[d][1]);

      for (int p = 0; p < 2; p++) begin
         ackp[d][p] = o_ack[d][p];
         if (o_ack[d][p]) begin
            ack_cnt[d][p]++;
            last_ack[d][p]  = cyc;
            rd_at_ack[d][p] = o_rd[d][p];
            if (log_order && d == 0) order_q.push_back(p);
         end
      end
      if (o_en[d]) begin
         last_en[d] = cyc; last_en_we[d] = o_we[d];
         last_en_addr[d] = o_addr[d]; last_en_wdata[d] = o_wdata[d];
         if (o_we[d]) memv[d][o_addr[d][5:0]] = o_wdata[d];
         else begin rd_due[d] = cyc + lat(d); rd_val[d] = memv[d][o_addr[d][5:0]]; end
      end

      if (reset) begin
         if (!m_we[d] && cyc == en_cyc[d] + lat(d)) m_rd[d][m_owner[d]] = mrd_v[d];
         if (cyc >= free_at[d] && (req_v[d][0] || req_v[d][1])) begin
            win = (req_v[d][1] && (!req_v[d][0] || m_cnt[d] == MAXG)) ? 1 : 0;
            m_owner[d] = win;
            m_we[d]    = we_v[d][win];
            m_addr[d]  = addr_v[d][win];
            m_wdata[d] = wdata_v[d][win];
            en_cyc[d]  = cyc + 1;
            ack_cyc[d] = cyc + 2 + lat(d);
            free_at[d] = cyc + 3 + lat(d);
            if (win == 1 || !req_v[d][1]) m_cnt[d] = 0;
            else if (m_cnt[d] < MAXG) m_cnt[d]++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic eval();
      for (int d = 0; d < 2; d++) begin
         agent(d, 0);
         agent(d, 1);
         mrd_v[d] = (cyc == rd_due[d]) ? rd_val[d] : $urandom;
         if (!reset) model_reset(d);
      end
      #1;
      for (int d = 0; d < 2; d++) check_and_update(d);
   endtask

   task automatic cycle();
      tick();
      eval();
   endtask

   task automatic wait_ack(input int d, input int p, input int budget);
      int start, n;
      start = ack_cnt[d][p];
      n = 0;
      while (ack_cnt[d][p] == start && n < budget) begin
         cycle();
         n++;
      end
      chk("ack_timeout", d, 32'(ack_cnt[d][p] != start), 32'd1);
   endtask

   int T, R, c0, c1, c_cpu;

   initial begin
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         model_reset(d);
         mrd_v[d] = '0;
         last_en[d] = -100;
         for (int i = 0; i < 64; i++) memv[d][i] = $urandom;
         for (int p = 0; p < 2; p++) begin
            req_v[d][p] = 1'b0; we_v[d][p] = 1'b0; addr_v[d][p] = '0; wdata_v[d][p] = '0;
            mode[d][p] = M_ONESHOT; ackp[d][p] = 1'b0; ack_cnt[d][p] = 0; last_ack[d][p] = -100;
         end
      end
      memv[0][16] = 32'hDEADBEEF;
      memv[1][16] = 32'hCAFEF00D;

      // reset state
      cycle(); cycle();
      tick(); reset = 1'b1; eval();
      cycle();

      // 1: CPU read 0x10 on the MEM_LAT=1 arbiter
      tick(); T = cyc;
      req_v[0][0] = 1'b1; we_v[0][0] = 1'b0; addr_v[0][0] = 32'h10; wdata_v[0][0] = $urandom;
      eval();
      wait_ack(0, 0, 20);
      chk("t1_en_time",  0, 32'(last_en[0] - T), 32'd1);
      chk("t1_en_addr",  0, last_en_addr[0], 32'h10);
      chk("t1_en_we",    0, 32'(last_en_we[0]), 32'd0);
      chk("t1_ack_time", 0, 32'(last_ack[0][0] - T), 32'd3);
      chk("t1_rdata",    0, rd_at_ack[0][0], 32'hDEADBEEF);

      // 2: debug write 0x20 <- 0x1234
      cycle();
      tick(); T = cyc; c_cpu = ack_cnt[0][0];
      req_v[0][1] = 1'b1; we_v[0][1] = 1'b1; addr_v[0][1] = 32'h20; wdata_v[0][1] = 32'h00001234;
      eval();
      wait_ack(0, 1, 20);
      chk("t2_en_we",    0, 32'(last_en_we[0]), 32'd1);
      chk("t2_en_addr",  0, last_en_addr[0], 32'h20);
      chk("t2_en_wdata", 0, last_en_wdata[0], 32'h00001234);
      chk("t2_ack_time", 0, 32'(last_ack[0][1] - T), 32'd3);
      chk("t2_cpu_acks", 0, 32'(ack_cnt[0][0]), 32'(c_cpu));
      chk("t2_cpu_rd",   0, o_rd[0][0], 32'hDEADBEEF);

      // 6: CPU write whose request fields change during ISSUE
      cycle();
      tick();
      req_v[0][0] = 1'b1; we_v[0][0] = 1'b1; addr_v[0][0] = 32'h05; wdata_v[0][0] = 32'hA5A50001;
      eval();
      tick(); addr_v[0][0] = 32'h3F; wdata_v[0][0] = 32'hFFFF0000; we_v[0][0] = 1'b0; eval();
      wait_ack(0, 0, 20);
      chk("t6_en_addr",  0, last_en_addr[0], 32'h05);
      chk("t6_en_wdata", 0, last_en_wdata[0], 32'hA5A50001);
      chk("t6_en_we",    0, 32'(last_en_we[0]), 32'd1);

      // 3: both ports held continuously, grant order under the starvation limit
      cycle();
      order_q.delete(); log_order = 1;
      mode[0][0] = M_HOLD; mode[0][1] = M_HOLD;
      tick();
      req_v[0][0] = 1'b1; we_v[0][0] = 1'b0; addr_v[0][0] = 32'h01;
      req_v[0][1] = 1'b1; we_v[0][1] = 1'b0; addr_v[0][1] = 32'h02;
      eval();
      for (int n = 0; n < 200 && order_q.size() < 10; n++) cycle();
      log_order = 0;
      tick(); req_v[0][0] = 1'b0; req_v[0][1] = 1'b0; mode[0][0] = M_ONESHOT; mode[0][1] = M_ONESHOT; eval();
      chk("t3_count", 0, 32'(order_q.size()), 32'd10);
      for (int i = 0; i < order_q.size() && i < 10; i++)
         chk($sformatf("t3_order%0d", i), 0, 32'(order_q[i]), (i % 5 == 4) ? 32'd1 : 32'd0);

      // 4: CPU read on the MEM_LAT=3 arbiter
      cycle(); cycle();
      tick(); T = cyc;
      req_v[1][0] = 1'b1; we_v[1][0] = 1'b0; addr_v[1][0] = 32'h10;
      eval();
      wait_ack(1, 0, 30);
      chk("t4_en_time",  1, 32'(last_en[1] - T), 32'd1);
      chk("t4_ack_time", 1, 32'(last_ack[1][0] - T), 32'd5);
      chk("t4_rdata",    1, rd_at_ack[1][0], 32'hCAFEF00D);

      // 5: reset during WAIT with the CPU request held
      cycle();
      mode[0][0] = M_HOLD; mode[1][0] = M_HOLD;
      tick();
      for (int d = 0; d < 2; d++) begin
         req_v[d][0] = 1'b1; we_v[d][0] = 1'b0; addr_v[d][0] = 32'h10;
      end
      eval();
      cycle();
      tick(); reset = 1'b0; eval();
      c0 = ack_cnt[0][0]; c1 = ack_cnt[1][0];
      chk("t5_rd_cleared", 0, o_rd[0][0], 32'h0);
      chk("t5_en_cleared", 1, 32'(o_en[1]), 32'd0);
      cycle(); cycle();
      tick(); reset = 1'b1; R = cyc; eval();
      chk("t5_no_ack0", 0, 32'(ack_cnt[0][0]), 32'(c0));
      chk("t5_no_ack1", 1, 32'(ack_cnt[1][0]), 32'(c1));
      wait_ack(0, 0, 20);
      chk("t5_reissue_en",  0, 32'(last_en[0] - R), 32'd1);
      chk("t5_reissue_ack", 0, 32'(last_ack[0][0] - R), 32'd3);
      wait_ack(1, 0, 20);
      chk("t5_reissue_ack", 1, 32'(last_ack[1][0] - R), 32'd5);
      tick();
      for (int d = 0; d < 2; d++) begin req_v[d][0] = 1'b0; mode[d][0] = M_ONESHOT; end
      eval();
      cycle(); cycle(); cycle();

      // random traffic on both arbiters with occasional reset pulses
      for (int d = 0; d < 2; d++) begin mode[d][0] = M_RANDOM; mode[d][1] = M_RANDOM; end
      for (int n = 0; n < 3000; n++) begin
         tick();
         reset = ($urandom_range(399) != 0);
         eval();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
